cla_pipe_adder: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the single-bit full-adder tile.

---
 rtl/cla_pipe_adder_if.sv | 32 +++
 rtl/cla_pipe_adder.sv | 136 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_if.sv
// Streaming operand/result bus for cla_pipe_adder.
// Operand side: in_valid/in_ready handshake carrying in_a, in_b, in_cin, in_sub.
// Result side:  out_valid/out_ready handshake carrying out_sum, out_cout, out_ovf.
// master: operand source and result consumer; slave: the adder.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Operands are split into GROUP-bit lookahead groups; stage k resolves bits
// [k*GROUP +: GROUP] and registers the group carry for stage k+1.
// Latency is NSTG = WIDTH/GROUP cycles, throughput one op per cycle.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous reset, active-high
//   bus  - slave side of cla_pipe_adder_if (operand and result handshakes)
// WIDTH must be a non-zero multiple of GROUP.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic            clk,
  input  logic            rst,
  cla_pipe_adder_if.slave bus
);

  localparam int unsigned NSTG = WIDTH / GROUP;

  // Flattened lookahead: every carry is a sum of products of g/p and c0,
  // so no carry depends on a lower carry output.
  function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] g,
                                               input logic [GROUP-1:0] p,
                                               input logic             c0);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < int'(GROUP); i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Pipeline registers after stage k. Skew operands are kept shifted so the
  // next unresolved group always sits in the low GROUP bits.
  logic             r_v   [NSTG];
  logic             r_c   [NSTG];
  logic [WIDTH-1:0] r_a   [NSTG];
  logic [WIDTH-1:0] r_b   [NSTG];
  logic [WIDTH-1:0] r_s   [NSTG];
  logic             r_ovf;

  // Stage inputs and next-state values.
  logic             w_vi  [NSTG];
  logic             w_ci  [NSTG];
  logic [WIDTH-1:0] w_ai  [NSTG];
  logic [WIDTH-1:0] w_bi  [NSTG];
  logic [WIDTH-1:0] w_si  [NSTG];
  logic             w_cn  [NSTG];
  logic [WIDTH-1:0] w_an  [NSTG];
  logic [WIDTH-1:0] w_bn  [NSTG];
  logic [WIDTH-1:0] w_sn  [NSTG];
  logic             w_ovf_n;
  logic             w_adv;

  // Whole pipeline shifts whenever the output slot is free or being taken.
  assign w_adv        = !r_v[NSTG-1] || bus.out_ready;
  assign bus.in_ready = w_adv && !rst;

  assign bus.out_valid = r_v[NSTG-1];
  assign bus.out_sum   = r_s[NSTG-1];
  assign bus.out_cout  = r_c[NSTG-1];
  assign bus.out_ovf   = r_ovf;

  // Stage input selection: stage 0 from the bus (B inverted for subtract),
  // later stages from the previous stage registers.
  always_comb begin
    w_vi[0] = bus.in_valid;
    w_ci[0] = bus.in_sub | bus.in_cin;
    w_ai[0] = bus.in_a;
    w_bi[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
    w_si[0] = '0;
    for (int k = 1; k < int'(NSTG); k++) begin
      w_vi[k] = r_v[k-1];
      w_ci[k] = r_c[k-1];
      w_ai[k] = r_a[k-1];
      w_bi[k] = r_b[k-1];
      w_si[k] = r_s[k-1];
    end
  end

  // Per-stage group resolution.
  always_comb begin
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_cy;
    w_g     = '0;
    w_p     = '0;
    w_cy    = '0;
    w_ovf_n = 1'b0;
    for (int k = 0; k < int'(NSTG); k++) begin
      w_g     = w_ai[k][GROUP-1:0] & w_bi[k][GROUP-1:0];
      w_p     = w_ai[k][GROUP-1:0] ^ w_bi[k][GROUP-1:0];
      w_cy    = lookahead(w_g, w_p, w_ci[k]);
      w_sn[k] = w_si[k] | (WIDTH'(w_p ^ w_cy[GROUP-1:0]) << (k * GROUP));
      w_an[k] = w_ai[k] >> GROUP;
      w_bn[k] = w_bi[k] >> GROUP;
      w_cn[k] = w_cy[GROUP];
      // Overflow: carry into MSB xor carry out of MSB, last group only.
      if (k == int'(NSTG) - 1) w_ovf_n = w_cy[GROUP] ^ w_cy[GROUP-1];
    end
  end

  // Pipeline registers; everything holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NSTG); k++) begin
        r_v[k] <= 1'b0;
        r_c[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < int'(NSTG); k++) begin
        r_v[k] <= w_vi[k];
        r_c[k] <= w_cn[k];
        r_a[k] <= w_an[k];
        r_b[k] <= w_bn[k];
        r_s[k] <= w_sn[k];
      end
      r_ovf <= w_ovf_n;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: three instances (8/4, 16/4, 8/8).
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(8))  if8  ();
  cla_pipe_adder_if #(.WIDTH(16)) if16 ();
  cla_pipe_adder_if #(.WIDTH(8))  if88 ();

  cla_pipe_adder #(.WIDTH(8),  .GROUP(4)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(8)) u_dut88 (.clk(clk), .rst(rst), .bus(if88));

  // Behavioural reference: returns {ovf, cout, sum[15:0]} for a w-bit adder.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin,
                                          input logic sub);
    logic [16:0] full;
    logic [15:0] mask, am, bb;
    logic        c0, co, ov;
    mask = 16'((17'd1 << w) - 17'd1);
    am   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, am} + {1'b0, bb} + 17'(c0);
    co   = full[w];
    ov   = (am[w-1] == bb[w-1]) && (full[w-1] != am[w-1]);
    return {ov, co, full[15:0] & mask};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", if8.out_valid); end
    n_chk++; if (if8.out_sum !== 8'h00) begin n_fail++; $display("FAIL reset_out_sum got=%h want=00", if8.out_sum); end
    n_chk++; if ({if8.out_cout, if8.out_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf got=%b%b want=00", if8.out_cout, if8.out_ovf); end
    n_chk++; if (if8.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", if8.in_ready); end
    n_chk++; if ({if16.out_valid, if88.out_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_other_valid got=%b%b want=00", if16.out_valid, if88.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b want=1", if8.in_ready); end
  endtask

  task automatic test_directed8();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic       vs [5];
    logic [9:0] ve [5];
    logic [9:0] got;
    int         lat;
    logic       seen;
    va = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h00};
    vb = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h00};
    vc = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    vs = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    ve = '{10'h100, 10'h280, 10'h0FE, 10'h37F, 10'h100};
    if8.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if8.in_valid = 1'b1; if8.in_a = va[i]; if8.in_b = vb[i];
      if8.in_cin = vc[i];  if8.in_sub = vs[i];
      lat = 0; seen = 1'b0;
      while (!seen && lat < 10) begin
        @(negedge clk); lat++; if8.in_valid = 1'b0; #1;
        if (if8.out_valid === 1'b1) seen = 1'b1;
      end
      got = {if8.out_ovf, if8.out_cout, if8.out_sum};
      n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL directed8_latency[%0d] got=%0d want=2", i, lat); end
      n_chk++; if (got !== ve[i]) begin n_fail++; $display("FAIL directed8_result[%0d] got=%h want=%h", i, got, ve[i]); end
    end
  endtask

  task automatic test_stream();
    logic [9:0]  q_exp [$];
    int          q_cyc [$];
    logic [9:0]  got, exp;
    logic [17:0] r;
    logic [7:0]  a, b;
    logic        cin, sub;
    int          issued = 0, recvd = 0, cyc = 0, lat;
    if8.out_ready = 1'b1;
    while ((issued < 256 || q_exp.size() != 0) && cyc < 300) begin
      @(negedge clk); #1;
      if (if8.out_valid === 1'b1) begin
        got = {if8.out_ovf, if8.out_cout, if8.out_sum};
        if (q_exp.size() == 0) begin
          n_chk++; n_fail++; $display("FAIL stream_extra got=%h want=none", got);
        end else begin
          exp = q_exp.pop_front();
          lat = cyc - q_cyc.pop_front();
          recvd++;
          n_chk++; if (got !== exp) begin n_fail++; $display("FAIL stream_result[%0d] got=%h want=%h", recvd, got, exp); end
          n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL stream_latency[%0d] got=%0d want=2", recvd, lat); end
        end
      end
      if (issued < 256) begin
        n_chk++; if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got=%b want=1", issued, if8.in_ready); end
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        if8.in_valid = 1'b1; if8.in_a = a; if8.in_b = b; if8.in_cin = cin; if8.in_sub = sub;
        r = ref_add(8, {8'h00, a}, {8'h00, b}, cin, sub);
        q_exp.push_back({r[17], r[16], r[7:0]});
        q_cyc.push_back(cyc);
        issued++;
      end else begin
        if8.in_valid = 1'b0;
      end
      cyc++;
    end
    n_chk++; if (recvd !== 256) begin n_fail++; $display("FAIL stream_count got=%0d want=256", recvd); end
  endtask

  task automatic test_backpressure();
    logic [9:0]  q_exp [$];
    logic [9:0]  got, exp;
    logic [7:0]  held, a, b;
    logic [17:0] r;
    logic        stall, sub;
    int          issued = 0, recvd = 0;
    for (int c = 0; c < 40 && recvd < 8; c++) begin
      @(negedge clk);
      stall = (c >= 3 && c <= 5);
      if8.out_ready = !stall;
      #1;
      n_chk++; if (if8.in_ready !== !stall) begin n_fail++; $display("FAIL bp_in_ready[c%0d] got=%b want=%b", c, if8.in_ready, !stall); end
      if (c == 3) begin
        held = if8.out_sum;
        n_chk++; if (if8.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full got=%b want=1", if8.out_valid); end
      end
      if (c == 4 || c == 5) begin
        n_chk++; if (if8.out_sum !== held) begin n_fail++; $display("FAIL bp_hold[c%0d] got=%h want=%h", c, if8.out_sum, held); end
      end
      if (if8.out_valid === 1'b1 && !stall) begin
        got = {if8.out_ovf, if8.out_cout, if8.out_sum};
        exp = (q_exp.size() != 0) ? q_exp.pop_front() : 10'h3FF;
        recvd++;
        n_chk++; if (got !== exp) begin n_fail++; $display("FAIL bp_result[%0d] got=%h want=%h", recvd, got, exp); end
      end
      if (issued < 8) begin
        a = 8'(issued * 17); b = 8'(8'hC3 + 8'(issued * 5)); sub = 1'(issued);
        if8.in_valid = 1'b1; if8.in_a = a; if8.in_b = b; if8.in_cin = 1'b0; if8.in_sub = sub;
        if (!stall) begin
          r = ref_add(8, {8'h00, a}, {8'h00, b}, 1'b0, sub);
          q_exp.push_back({r[17], r[16], r[7:0]});
          issued++;
        end
      end else begin
        if8.in_valid = 1'b0;
      end
    end
    if8.out_ready = 1'b1;
    n_chk++; if (recvd !== 8) begin n_fail++; $display("FAIL bp_count got=%0d want=8", recvd); end
    n_chk++; if (q_exp.size() !== 0) begin n_fail++; $display("FAIL bp_leftover got=%0d want=0", q_exp.size()); end
  endtask

  task automatic test_reset_midflight();
    int         lat;
    logic       seen;
    logic [9:0] got;
    @(negedge clk);
    if8.out_ready = 1'b0;
    if8.in_valid = 1'b1; if8.in_a = 8'h11; if8.in_b = 8'h22; if8.in_cin = 1'b0; if8.in_sub = 1'b0;
    @(negedge clk);
    if8.in_a = 8'h33; if8.in_b = 8'h44;
    @(negedge clk);
    if8.in_valid = 1'b0;
    #1;
    n_chk++; if (if8.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got=%b want=1", if8.out_valid); end
    rst = 1'b1;
    #1;
    n_chk++; if (if8.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready got=%b want=0", if8.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b want=0", if8.out_valid); end
    n_chk++; if (if8.out_sum !== 8'h00) begin n_fail++; $display("FAIL mid_out_sum got=%h want=00", if8.out_sum); end
    if8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_chk++; if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d] got=%b want=0", i, if8.out_valid); end
    end
    @(negedge clk);
    if8.in_valid = 1'b1; if8.in_a = 8'h9C; if8.in_b = 8'h64; if8.in_cin = 1'b1; if8.in_sub = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk); lat++; if8.in_valid = 1'b0; #1;
      if (if8.out_valid === 1'b1) seen = 1'b1;
    end
    got = {if8.out_ovf, if8.out_cout, if8.out_sum};
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL mid_next_latency got=%0d want=2", lat); end
    n_chk++; if (got !== 10'h101) begin n_fail++; $display("FAIL mid_next_result got=%h want=101", got); end
  endtask

  task automatic test_width16();
    logic [15:0] va [11];
    logic [15:0] vb [11];
    logic        vc [11];
    logic        vs [11];
    logic [17:0] ve [11];
    logic [17:0] got;
    int          lat;
    logic        seen;
    va[0] = 16'hFFFF; vb[0] = 16'h0000; vc[0] = 1'b1; vs[0] = 1'b0; ve[0] = 18'h10000;
    va[1] = 16'h7FFF; vb[1] = 16'h0001; vc[1] = 1'b0; vs[1] = 1'b0; ve[1] = 18'h28000;
    va[2] = 16'h1234; vb[2] = 16'h1235; vc[2] = 1'b0; vs[2] = 1'b1; ve[2] = 18'h0FFFF;
    for (int i = 3; i < 11; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom); vs[i] = 1'($urandom);
      ve[i] = ref_add(16, va[i], vb[i], vc[i], vs[i]);
    end
    if16.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if16.in_valid = 1'b1; if16.in_a = va[i]; if16.in_b = vb[i];
      if16.in_cin = vc[i];  if16.in_sub = vs[i];
      lat = 0; seen = 1'b0;
      while (!seen && lat < 12) begin
        @(negedge clk); lat++; if16.in_valid = 1'b0; #1;
        if (if16.out_valid === 1'b1) seen = 1'b1;
      end
      got = {if16.out_ovf, if16.out_cout, if16.out_sum};
      n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL w16_latency[%0d] got=%0d want=4", i, lat); end
      n_chk++; if (got !== ve[i]) begin n_fail++; $display("FAIL w16_result[%0d] got=%h want=%h", i, got, ve[i]); end
    end
  endtask

  task automatic test_group8();
    logic [7:0]  va [10];
    logic [7:0]  vb [10];
    logic        vc [10];
    logic        vs [10];
    logic [9:0]  ve [10];
    logic [17:0] r;
    logic [9:0]  got;
    int          lat;
    logic        seen;
    va[0] = 8'h05; vb[0] = 8'h07; vc[0] = 1'b1; vs[0] = 1'b1; ve[0] = 10'h0FE;
    va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0; vs[1] = 1'b0; ve[1] = 10'h100;
    for (int i = 2; i < 10; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom); vc[i] = 1'($urandom); vs[i] = 1'($urandom);
      r = ref_add(8, {8'h00, va[i]}, {8'h00, vb[i]}, vc[i], vs[i]);
      ve[i] = {r[17], r[16], r[7:0]};
    end
    if88.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if88.in_valid = 1'b1; if88.in_a = va[i]; if88.in_b = vb[i];
      if88.in_cin = vc[i];  if88.in_sub = vs[i];
      lat = 0; seen = 1'b0;
      while (!seen && lat < 10) begin
        @(negedge clk); lat++; if88.in_valid = 1'b0; #1;
        if (if88.out_valid === 1'b1) seen = 1'b1;
      end
      got = {if88.out_ovf, if88.out_cout, if88.out_sum};
      n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL g8_latency[%0d] got=%0d want=1", i, lat); end
      n_chk++; if (got !== ve[i]) begin n_fail++; $display("FAIL g8_result[%0d] got=%h want=%h", i, got, ve[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    if8.in_valid  = 1'b0; if8.in_a  = '0; if8.in_b  = '0; if8.in_cin  = 1'b0; if8.in_sub  = 1'b0; if8.out_ready  = 1'b1;
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_cin = 1'b0; if16.in_sub = 1'b0; if16.out_ready = 1'b1;
    if88.in_valid = 1'b0; if88.in_a = '0; if88.in_b = '0; if88.in_cin = 1'b0; if88.in_sub = 1'b0; if88.out_ready = 1'b1;
    test_reset();
    test_directed8();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_width16();
    test_group8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
